// File: rtl/ask_bit_slicer.sv
// ask_bit_slicer: hysteresis slicer on the magnitude stream plus oversampled
// recovery of 1-start/8-data/1-stop bytes.
module ask_bit_slicer #(
  parameter int          SPS    = 16,
  parameter logic [15:0] THR_HI = 16'd1000,
  parameter logic [15:0] THR_LO = 16'd500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mag,
  input  logic        mag_valid,
  output logic [7:0]  data,
  output logic        data_valid,
  output logic        frame_err,
  output logic        busy,
  output logic        level
);
  localparam int CW = $clog2(SPS);
  localparam logic [CW-1:0] HALF = CW'(SPS / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(SPS - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bidx;
  logic [7:0]    r_shift;
  logic          w_lvl_next;
  logic          w_half;
  logic          w_full;
  assign w_lvl_next = (mag >= THR_HI) ? 1'b1 : (mag <= THR_LO) ? 1'b0 : level;
  assign w_half     = r_cnt == HALF;
  assign w_full     = r_cnt == FULL;
  // Every decision looks at the incoming sliced sample, not the registered level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bidx     <= '0;
      r_shift    <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      level      <= 1'b1;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (mag_valid) begin
        level <= w_lvl_next;
        case (r_state)
          IDLE: if (level && !w_lvl_next) begin
            r_cnt   <= '0;
            r_state <= START;
            busy    <= 1'b1;
          end
          START: if (w_half) begin
            r_cnt  <= '0;
            r_bidx <= '0;
            if (!w_lvl_next) r_state <= DATA;
            else begin
              r_state <= IDLE;
              busy    <= 1'b0;
            end
          end else r_cnt <= r_cnt + 1'b1;
          DATA: if (w_full) begin
            r_shift <= {w_lvl_next, r_shift[7:1]};
            r_cnt   <= '0;
            r_bidx  <= r_bidx + 3'd1;
            if (r_bidx == 3'd7) r_state <= STOP;
          end else r_cnt <= r_cnt + 1'b1;
          STOP: if (w_full) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            busy    <= 1'b0;
            if (w_lvl_next) begin
              data       <= r_shift;
              data_valid <= 1'b1;
            end else frame_err <= 1'b1;
          end else r_cnt <= r_cnt + 1'b1;
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ask_bit_slicer.sv
// tb_ask_bit_slicer: directed scenarios for the ASK bit slicer with
// hand-computed sample indices, pulse counts and received bytes.
module tb_ask_bit_slicer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mag = 16'd2000;
  logic        mag_valid = 1'b0;
  logic [7:0]  data;
  logic        data_valid;
  logic        frame_err;
  logic        busy;
  logic        level;

  ask_bit_slicer #(.SPS(16), .THR_HI(16'd1000), .THR_LO(16'd500)) dut (
    .clk(clk), .rst_n(rst_n), .mag(mag), .mag_valid(mag_valid),
    .data(data), .data_valid(data_valid), .frame_err(frame_err),
    .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int cyc = 0, nidx = 0, cur_idx = -1, f_cyc = 0;
  int dv_n = 0, fe_n = 0, both_n = 0, dv_idx = -1, dv_cyc = 0, rise = -1, fall = -1;
  logic [7:0] fe_data = 8'h00;
  logic pb = 1'b0;

  // Pulse/edge recorder, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (data_valid) begin
      dv_n++;
      dv_idx = cur_idx;
      dv_cyc = cyc;
    end
    if (frame_err) begin
      fe_n++;
      fe_data = data;
    end
    if (data_valid && frame_err) both_n++;
    if (busy && !pb) rise = cur_idx;
    if (!busy && pb) fall = cur_idx;
    pb = busy;
  end

  task automatic drive(input logic [15:0] m, input logic v);
    @(negedge clk);
    mag = m;
    mag_valid = v;
    if (v) begin
      if (nidx == 0) f_cyc = cyc;
      cur_idx = nidx;
      nidx++;
    end
  endtask

  task automatic send_sym(input logic b, input int gap);
    for (int i = 0; i < 16; i++) begin
      for (int g = 1; g < gap; g++) drive(16'd0, 1'b0);
      drive(b ? 16'd2000 : 16'd0, 1'b1);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap);
    nidx = 0;
    send_sym(1'b0, gap);
    for (int i = 0; i < 8; i++) send_sym(d[i], gap);
    send_sym(stop, gap);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(16'd2000, 1'b1);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    nvec++; if (data !== 8'h00) begin nerr++; $display("FAIL reset_data got %h want 00", data); end
    nvec++; if (data_valid !== 1'b0) begin nerr++; $display("FAIL reset_dv got %b want 0", data_valid); end
    nvec++; if (frame_err !== 1'b0) begin nerr++; $display("FAIL reset_fe got %b want 0", frame_err); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
    nvec++; if (level !== 1'b1) begin nerr++; $display("FAIL reset_level got %b want 1", level); end
    rst_n = 1'b1;
    idle(10);
  endtask

  task automatic test_clean;
    int d0, f0;
    d0 = dv_n; f0 = fe_n; rise = -1; fall = -1;
    send_frame(8'hA5, 1'b1, 1);
    idle(20);
    nvec++; if (dv_n - d0 !== 1) begin nerr++; $display("FAIL clean_dv_count got %0d want 1", dv_n - d0); end
    nvec++; if (dv_idx !== 152) begin nerr++; $display("FAIL clean_dv_index got %0d want 152", dv_idx); end
    nvec++; if (data !== 8'hA5) begin nerr++; $display("FAIL clean_data got %h want a5", data); end
    nvec++; if (fe_n - f0 !== 0) begin nerr++; $display("FAIL clean_fe_count got %0d want 0", fe_n - f0); end
    nvec++; if (rise !== 0) begin nerr++; $display("FAIL clean_busy_rise got %0d want 0", rise); end
    nvec++; if (fall !== 152) begin nerr++; $display("FAIL clean_busy_fall got %0d want 152", fall); end
  endtask

  task automatic test_hysteresis;
    logic [15:0] m [7] = '{16'd700, 16'd400, 16'd700, 16'd999, 16'd1000, 16'd999, 16'd500};
    logic        e [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    idle(2);
    for (int i = 0; i < 7; i++) begin
      drive(m[i], 1'b1);
      if (i == 1) begin
        #1;
        nvec++; if (level !== 1'b1) begin nerr++; $display("FAIL hyst_lag got %b want 1", level); end
      end
      @(posedge clk); #1;
      nvec++; if (level !== e[i]) begin nerr++; $display("FAIL hyst_%0d mag %0d got %b want %b", i, m[i], level, e[i]); end
    end
    idle(20);
  endtask

  task automatic test_glitch;
    int d0, f0;
    d0 = dv_n; f0 = fe_n; rise = -1; fall = -1;
    nidx = 0;
    for (int i = 0; i < 4; i++) drive(16'd0, 1'b1);
    idle(30);
    nvec++; if (rise !== 0) begin nerr++; $display("FAIL glitch_rise got %0d want 0", rise); end
    nvec++; if (fall !== 8) begin nerr++; $display("FAIL glitch_fall got %0d want 8", fall); end
    nvec++; if (dv_n - d0 !== 0) begin nerr++; $display("FAIL glitch_dv got %0d want 0", dv_n - d0); end
    nvec++; if (fe_n - f0 !== 0) begin nerr++; $display("FAIL glitch_fe got %0d want 0", fe_n - f0); end
    nvec++; if (data !== 8'hA5) begin nerr++; $display("FAIL glitch_data got %h want a5", data); end
  endtask

  task automatic test_frame_err;
    int d0, f0;
    d0 = dv_n; f0 = fe_n;
    send_frame(8'h3C, 1'b0, 1);
    drive(16'd0, 1'b1);
    rise = -1;
    for (int i = 1; i < 40; i++) drive(16'd0, 1'b1);
    @(posedge clk); #1;
    nvec++; if (fe_n - f0 !== 1) begin nerr++; $display("FAIL ferr_count got %0d want 1", fe_n - f0); end
    nvec++; if (fe_data !== 8'hA5) begin nerr++; $display("FAIL ferr_data_hold got %h want a5", fe_data); end
    nvec++; if (dv_n - d0 !== 0) begin nerr++; $display("FAIL ferr_dv got %0d want 0", dv_n - d0); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL ferr_busy_low got %b want 0", busy); end
    nvec++; if (rise !== -1) begin nerr++; $display("FAIL ferr_spurious_start got %0d want -1", rise); end
    idle(20);
    send_frame(8'h81, 1'b1, 1);
    idle(20);
    nvec++; if (dv_n - d0 !== 1) begin nerr++; $display("FAIL ferr_next_dv got %0d want 1", dv_n - d0); end
    nvec++; if (data !== 8'h81) begin nerr++; $display("FAIL ferr_next_data got %h want 81", data); end
  endtask

  task automatic test_stretched;
    int d0, f0;
    d0 = dv_n; f0 = fe_n;
    send_frame(8'h5A, 1'b1, 3);
    idle(20);
    nvec++; if (dv_n - d0 !== 1) begin nerr++; $display("FAIL stretch_dv got %0d want 1", dv_n - d0); end
    nvec++; if (data !== 8'h5A) begin nerr++; $display("FAIL stretch_data got %h want 5a", data); end
    nvec++; if (dv_cyc - f_cyc !== 457) begin nerr++; $display("FAIL stretch_latency got %0d want 457", dv_cyc - f_cyc); end
    nvec++; if (fe_n - f0 !== 0) begin nerr++; $display("FAIL stretch_fe got %0d want 0", fe_n - f0); end
  endtask

  task automatic test_reset_mid;
    int d0;
    logic [7:0] b;
    b = 8'hF0;
    d0 = dv_n;
    nidx = 0;
    send_sym(1'b0, 1);
    for (int i = 0; i < 4; i++) send_sym(b[i], 1);
    for (int i = 0; i < 5; i++) drive(16'd2000, 1'b1);
    #2;
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL rmid_busy_before got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rmid_busy got %b want 0", busy); end
    nvec++; if (data !== 8'h00) begin nerr++; $display("FAIL rmid_data got %h want 00", data); end
    nvec++; if (level !== 1'b1) begin nerr++; $display("FAIL rmid_level got %b want 1", level); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(11 + 3 * 16 + 16 + 20);
    nvec++; if (dv_n - d0 !== 0) begin nerr++; $display("FAIL rmid_tail_dv got %0d want 0", dv_n - d0); end
    send_frame(8'hFF, 1'b1, 1);
    idle(20);
    nvec++; if (dv_n - d0 !== 1) begin nerr++; $display("FAIL rmid_ff_dv got %0d want 1", dv_n - d0); end
    nvec++; if (data !== 8'hFF) begin nerr++; $display("FAIL rmid_ff_data got %h want ff", data); end
  endtask

  initial begin
    test_reset;
    test_clean;
    test_hysteresis;
    test_glitch;
    test_frame_err;
    test_stretched;
    test_reset_mid;
    nvec++; if (both_n !== 0) begin nerr++; $display("FAIL dv_fe_overlap got %0d want 0", both_n); end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
